// File: rtl/ex_mem.sv
// rtl/ex_mem.sv - EX/MEM pipeline register with stall, flush and accumulate feedback.
// Optional bubble counter enabled by defining EX_MEM_BUBBLE_CNT_EN.
module ex_mem #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int ALUOP_W = 8,
  parameter int CNT_W   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall,
  input  logic                flush,
  input  logic [ADDR_W-1:0]   ex_wd,
  input  logic                ex_wreg,
  input  logic [DATA_W-1:0]   ex_wdata,
  input  logic                ex_whilo,
  input  logic [DATA_W-1:0]   ex_hi,
  input  logic [DATA_W-1:0]   ex_lo,
  input  logic [ALUOP_W-1:0]  ex_aluop,
  input  logic [DATA_W-1:0]   ex_mem_addr,
  input  logic [DATA_W-1:0]   ex_reg2,
  input  logic [2*DATA_W-1:0] hilo_i,
  input  logic [CNT_W-1:0]    cnt_i,
  output logic [ADDR_W-1:0]   mem_wd,
  output logic                mem_wreg,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_whilo,
  output logic [DATA_W-1:0]   mem_hi,
  output logic [DATA_W-1:0]   mem_lo,
  output logic [ALUOP_W-1:0]  mem_aluop,
  output logic [DATA_W-1:0]   mem_mem_addr,
  output logic [DATA_W-1:0]   mem_reg2,
  output logic [2*DATA_W-1:0] hilo_o,
`ifdef EX_MEM_BUBBLE_CNT_EN
  output logic [15:0]         bubble_cnt,
`endif
  output logic [CNT_W-1:0]    cnt_o
);

  logic bubble;
  logic hold;

  // An execute stall with memory still running inserts a NOP into memory.
  assign bubble = stall[3] && !stall[4];
  assign hold   = stall[3] && stall[4];

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      mem_wd       <= '0;
      mem_wreg     <= 1'b0;
      mem_wdata    <= '0;
      mem_whilo    <= 1'b0;
      mem_hi       <= '0;
      mem_lo       <= '0;
      mem_aluop    <= '0;
      mem_mem_addr <= '0;
      mem_reg2     <= '0;
      hilo_o       <= '0;
      cnt_o        <= '0;
    end else if (bubble) begin
      mem_wd       <= '0;
      mem_wreg     <= 1'b0;
      mem_wdata    <= '0;
      mem_whilo    <= 1'b0;
      mem_hi       <= '0;
      mem_lo       <= '0;
      mem_aluop    <= '0;
      mem_mem_addr <= '0;
      mem_reg2     <= '0;
      hilo_o       <= hilo_i;
      cnt_o        <= cnt_i;
    end else if (!hold) begin
      mem_wd       <= ex_wd;
      mem_wreg     <= ex_wreg;
      mem_wdata    <= ex_wdata;
      mem_whilo    <= ex_whilo;
      mem_hi       <= ex_hi;
      mem_lo       <= ex_lo;
      mem_aluop    <= ex_aluop;
      mem_mem_addr <= ex_mem_addr;
      mem_reg2     <= ex_reg2;
      hilo_o       <= '0;
      cnt_o        <= '0;
    end
  end

`ifdef EX_MEM_BUBBLE_CNT_EN
  // Flush does not clear the count; it only suppresses the increment on that edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bubble_cnt <= '0;
    end else if (!flush && bubble && bubble_cnt != 16'hFFFF) begin
      bubble_cnt <= bubble_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ex_mem.sv
// tb/tb_ex_mem.sv - Self-checking bench for ex_mem (vector table plus randomized model).
// Define EX_MEM_BUBBLE_CNT_EN to also exercise the bubble counter.
module tb_ex_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata;
  logic        ex_whilo;
  logic [31:0] ex_hi, ex_lo, ex_mem_addr, ex_reg2;
  logic [7:0]  ex_aluop;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg, mem_whilo;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
  logic [7:0]  mem_aluop;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;
`ifdef EX_MEM_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ex_mem dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
    .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr),
    .ex_reg2(ex_reg2), .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
    .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
    .mem_reg2(mem_reg2), .hilo_o(hilo_o),
`ifdef EX_MEM_BUBBLE_CNT_EN
    .bubble_cnt(bubble_cnt),
`endif
    .cnt_o(cnt_o)
  );

  typedef struct packed {
    logic        rst;
    logic        flush;
    logic [5:0]  stall;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [63:0] hilo;
    logic [1:0]  cnt;
    logic [31:0] fill;
    logic [4:0]  e_wd;
    logic        e_wreg;
    logic [31:0] e_wdata;
    logic [63:0] e_hilo;
    logic [1:0]  e_cnt;
    logic [31:0] e_hi;
  } vec_t;

  // Expected pipeline-register contents, as the stage rules define them.
  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic        whilo;
    logic [31:0] hi, lo;
    logic [7:0]  aluop;
    logic [31:0] addr, reg2;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } model_t;

  vec_t   vecs[16];
  model_t m;
  int     m_bubbles;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic f, input logic [5:0] s, input logic [4:0] wd,
                       input logic wr, input logic [31:0] wdat, input logic [63:0] hl,
                       input logic [1:0] c, input logic [31:0] fill);
    @(negedge clk);
    rst = r; flush = f; stall = s; ex_wd = wd; ex_wreg = wr; ex_wdata = wdat;
    hilo_i = hl; cnt_i = c;
    ex_hi = fill; ex_lo = ~fill; ex_mem_addr = fill ^ 32'h0F0F_0F0F; ex_reg2 = fill + 32'd1;
    ex_aluop = fill[7:0]; ex_whilo = fill[0];
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic f, input logic [5:0] s, input logic [4:0] wd,
                              input logic wr, input logic [31:0] wdat, input logic [63:0] hl,
                              input logic [1:0] c, input logic [31:0] fill,
                              input logic [4:0] e_wd, input logic e_wr, input logic [31:0] e_wdat,
                              input logic [63:0] e_hl, input logic [1:0] e_c, input logic [31:0] e_hi);
    vec_t v;
    v = '{r, f, s, wd, wr, wdat, hl, c, fill, e_wd, e_wr, e_wdat, e_hl, e_c, e_hi};
    return v;
  endfunction

  // The aborted-or-empty state: everything zero.
  function automatic model_t model_step(input model_t cur);
    model_t n;
    n = cur;
    if (!rst || flush) begin
      n = '0;
    end else if (stall[3] && !stall[4]) begin
      n = '0;
      n.hilo = hilo_i;
      n.cnt  = cnt_i;
    end else if (stall[3] && stall[4]) begin
      n = cur;
    end else begin
      n = '{ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_aluop, ex_mem_addr, ex_reg2,
             64'h0, 2'd0};
    end
    return n;
  endfunction

  initial begin
    logic [63:0] ones;
    ones = '1;
    rst = 1'b0; flush = 1'b0; stall = '0; ex_wd = '0; ex_wreg = 1'b0; ex_wdata = '0;
    ex_whilo = 1'b0; ex_hi = '0; ex_lo = '0; ex_aluop = '0; ex_mem_addr = '0; ex_reg2 = '0;
    hilo_i = '0; cnt_i = '0;

    vecs[0]  = mk(0, 0, 6'h00, 5'h1F, 1, 32'hFFFF_FFFF, ones, 3, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 6'h00, 5'h1F, 1, 32'hFFFF_FFFF, ones, 3, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 6'h00, 5'd3, 1, 32'hDEAD_BEEF, 64'h1234, 1, 32'h1111_1111,
                  5'd3, 1, 32'hDEAD_BEEF, 0, 0, 32'h1111_1111);
    vecs[3]  = mk(1, 0, 6'h0F, 5'd3, 1, 32'h0ABC, 64'h1_0000_0002, 1, 32'h2222_2222,
                  0, 0, 0, 64'h1_0000_0002, 1, 0);
    vecs[4]  = mk(1, 1, 6'h0F, 5'd3, 1, 32'h0ABC, 64'h1_0000_0002, 1, 32'h2222_2222, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 0, 6'h00, 5'd7, 1, 32'h55, 0, 0, 32'h3333_3333, 5'd7, 1, 32'h55, 0, 0, 32'h3333_3333);
    vecs[6]  = mk(1, 0, 6'h1F, 5'd9, 0, 32'h66, 5, 1, 32'h4444_4444, 5'd7, 1, 32'h55, 0, 0, 32'h3333_3333);
    vecs[7]  = mk(1, 0, 6'h1F, 5'd9, 0, 32'h77, 5, 1, 32'h4444_4444, 5'd7, 1, 32'h55, 0, 0, 32'h3333_3333);
    vecs[8]  = mk(1, 0, 6'h1F, 5'd9, 0, 32'h88, 5, 1, 32'h4444_4444, 5'd7, 1, 32'h55, 0, 0, 32'h3333_3333);
    vecs[9]  = mk(1, 0, 6'h0F, 5'd9, 1, 32'h99, 64'hAAAA_BBBB_CCCC_DDDD, 2, 32'h5555_5555,
                  0, 0, 0, 64'hAAAA_BBBB_CCCC_DDDD, 2, 0);
    vecs[10] = mk(1, 0, 6'h1F, 5'd4, 1, 32'h100, 64'h1, 1, 32'h666,
                  0, 0, 0, 64'hAAAA_BBBB_CCCC_DDDD, 2, 0);
    vecs[11] = mk(1, 0, 6'h3F, 5'd5, 1, 32'h101, 64'h2, 3, 32'h667,
                  0, 0, 0, 64'hAAAA_BBBB_CCCC_DDDD, 2, 0);
    vecs[12] = mk(0, 0, 6'h0F, 5'd5, 1, 32'h102, 64'h5, 1, 32'h668, 0, 0, 0, 0, 0, 0);
    vecs[13] = mk(1, 0, 6'h10, 5'd2, 1, 32'h1234, 64'h9, 1, 32'h777, 5'd2, 1, 32'h1234, 0, 0, 32'h777);
    vecs[14] = mk(1, 0, 6'h0F, 5'd2, 1, 32'h1234, 64'hF, 1, 32'h888, 0, 0, 0, 64'hF, 1, 0);
    vecs[15] = mk(1, 0, 6'h00, 5'd6, 0, 32'h42, 64'hF, 1, 32'h999, 5'd6, 0, 32'h42, 0, 0, 32'h999);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].rst, vecs[i].flush, vecs[i].stall, vecs[i].wd, vecs[i].wreg,
            vecs[i].wdata, vecs[i].hilo, vecs[i].cnt, vecs[i].fill);
      check($sformatf("vec%0d_wd", i), 64'(mem_wd), 64'(vecs[i].e_wd));
      check($sformatf("vec%0d_wreg", i), 64'(mem_wreg), 64'(vecs[i].e_wreg));
      check($sformatf("vec%0d_wdata", i), 64'(mem_wdata), 64'(vecs[i].e_wdata));
      check($sformatf("vec%0d_hilo", i), hilo_o, vecs[i].e_hilo);
      check($sformatf("vec%0d_cnt", i), 64'(cnt_o), 64'(vecs[i].e_cnt));
      check($sformatf("vec%0d_hi", i), 64'(mem_hi), 64'(vecs[i].e_hi));
    end

    // Randomized traffic against the model, starting from a known reset state.
    drive(0, 0, 6'h00, 0, 0, 0, 0, 0, 0);
    m = '0;
    m_bubbles = 0;
    for (int i = 0; i < 400; i++) begin
      int sel;
      logic [5:0] s;
      logic r, f;
      sel = int'($urandom_range(0, 9));
      if (sel < 4)       s = {2'b00, 1'b0, 3'($urandom)};
      else if (sel < 7)  s = {1'b0, 1'b0, 1'b1, 3'($urandom)};
      else if (sel < 9)  s = {1'($urandom), 1'b1, 1'b1, 3'($urandom)};
      else               s = 6'b010000;
      r = ($urandom_range(0, 29) != 0);
      f = ($urandom_range(0, 19) == 0);
      drive(r, f, s, 5'($urandom), 1'($urandom), $urandom, {$urandom, $urandom}, 2'($urandom), $urandom);
      m = model_step(m);
      if (!rst) m_bubbles = 0;
      else if (!flush && stall[3] && !stall[4] && m_bubbles < 65535) m_bubbles++;
      check("rand_wd", 64'(mem_wd), 64'(m.wd));
      check("rand_wreg", 64'({mem_wreg, mem_whilo}), 64'({m.wreg, m.whilo}));
      check("rand_wdata", 64'(mem_wdata), 64'(m.wdata));
      check("rand_hilo_regs", {mem_hi, mem_lo}, {m.hi, m.lo});
      check("rand_aluop", 64'(mem_aluop), 64'(m.aluop));
      check("rand_addr_reg2", {mem_mem_addr, mem_reg2}, {m.addr, m.reg2});
      check("rand_acc", {hilo_o[61:0], cnt_o}, {m.hilo[61:0], m.cnt});
      check("rand_acc_top", 64'(hilo_o[63:62]), 64'(m.hilo[63:62]));
`ifdef EX_MEM_BUBBLE_CNT_EN
      check("rand_bubble_cnt", 64'(bubble_cnt), 64'(m_bubbles));
`endif
    end

`ifdef EX_MEM_BUBBLE_CNT_EN
    drive(0, 0, 6'h00, 0, 0, 0, 0, 0, 0);
    check("bcnt_reset", 64'(bubble_cnt), 64'd0);
    for (int i = 0; i < 3; i++) drive(1, 0, 6'h0F, 0, 0, 0, 64'h1, 1, 0);
    drive(1, 1, 6'h0F, 0, 0, 0, 64'h1, 1, 0);
    check("bcnt_three_then_flush", 64'(bubble_cnt), 64'd3);
    for (int i = 0; i < 65532; i++) drive(1, 0, 6'h0F, 0, 0, 0, 64'h1, 1, 0);
    check("bcnt_reach_max", 64'(bubble_cnt), 64'hFFFF);
    drive(1, 0, 6'h0F, 0, 0, 0, 64'h1, 1, 0);
    check("bcnt_saturate", 64'(bubble_cnt), 64'hFFFF);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
